// File: rtl/udm_bus_arb.sv
// Two-master to one-slave udm bus arbiter. Master 0 is the debug controller,
// master 1 the CPU data port; read responses are steered back via an ID FIFO.
module udm_bus_arb #(
    parameter string M0_PRIORITY     = "YES",
    parameter int    RESP_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    output logic        m0_ack_o,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    output logic        m1_ack_o,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    input  logic        s_ack_i,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic        resp_err_o
);

    localparam bit FIXED_PRIO = (M0_PRIORITY == "YES");
    localparam int PTR_W      = $clog2(RESP_FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(RESP_FIFO_DEPTH);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t           state, state_nxt;
    logic             grant_id;
    logic             rr_prio;
    logic             pick;
    logic             g_req, g_we;
    logic             fifo_full, fifo_empty, stall;
    logic             s_go, done, push, pop, head_id;
    logic             fifo_mem [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    // On a tie, rr_prio names the master that was not served last.
    always_comb begin
        pick = !m0_req_i;
        if (m0_req_i && m1_req_i)
            pick = FIXED_PRIO ? 1'b0 : rr_prio;
    end

    assign g_req      = grant_id ? m1_req_i : m0_req_i;
    assign g_we       = grant_id ? m1_we_i  : m0_we_i;
    assign fifo_full  = (count == FIFO_FULL_CNT);
    assign fifo_empty = (count == '0);
    assign stall      = !g_we && fifo_full;
    assign s_go       = (state == GRANTED) && g_req && !stall;
    assign done       = s_go && s_ack_i;
    assign push       = done && !g_we;
    assign pop        = s_resp_i && !fifo_empty;
    assign head_id    = fifo_mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_req_i || m1_req_i) state_nxt = GRANTED;
            GRANTED: if (done)                 state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        if (state == GRANTED) begin
            s_req_o    = s_go;
            s_we_o     = g_we;
            s_addr_bo  = grant_id ? m1_addr_bi  : m0_addr_bi;
            s_be_bo    = grant_id ? m1_be_bi    : m0_be_bi;
            s_wdata_bo = grant_id ? m1_wdata_bi : m0_wdata_bi;
            m0_ack_o   = s_ack_i && !grant_id;
            m1_ack_o   = s_ack_i &&  grant_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_id <= 1'b0;
            rr_prio  <= 1'b0;
        end else begin
            if (state == IDLE && (m0_req_i || m1_req_i))
                grant_id <= pick;
            if (done)
                rr_prio <= !grant_id;
        end
    end

    // Outstanding-read ID FIFO; count is one bit wider than the pointers.
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= grant_id;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            resp_err_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_resp_i && fifo_empty)
                resp_err_o <= 1'b1;
        end
    end

    assign m0_resp_o   = pop && !head_id;
    assign m1_resp_o   = pop &&  head_id;
    assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

endmodule

// File: tb/tb_udm_bus_arb.sv
// Scoreboard bench for udm_bus_arb: fixed-priority instance checked throughout,
// a round-robin instance on the same inputs checked for grant alternation.
module tb_udm_bus_arb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
    logic [31:0] m0_addr_bi = 0, m0_wdata_bi = 0, m1_addr_bi = 0, m1_wdata_bi = 0;
    logic [3:0]  m0_be_bi = 0, m1_be_bi = 0;
    logic        s_ack_i = 0, s_resp_i = 0;
    logic [31:0] s_rdata_bi = 0;

    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o, resp_err_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;

    logic        rr_m0_ack, rr_m0_resp, rr_m1_ack, rr_m1_resp;
    logic [31:0] rr_m0_rdata, rr_m1_rdata;
    logic        rr_s_req, rr_s_we, rr_resp_err;
    logic [31:0] rr_s_addr, rr_s_wdata;
    logic [3:0]  rr_s_be;

    always #5 clk_i = ~clk_i;

    udm_bus_arb #(.M0_PRIORITY("YES"), .RESP_FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_ack_o(m0_ack_o), .m0_we_i(m0_we_i),
        .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi),
        .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_ack_o(m1_ack_o), .m1_we_i(m1_we_i),
        .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi),
        .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_ack_i(s_ack_i), .s_we_o(s_we_o),
        .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
        .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .resp_err_o(resp_err_o)
    );

    udm_bus_arb #(.M0_PRIORITY("NO"), .RESP_FIFO_DEPTH(4)) dut_rr (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_ack_o(rr_m0_ack), .m0_we_i(m0_we_i),
        .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi),
        .m0_resp_o(rr_m0_resp), .m0_rdata_bo(rr_m0_rdata),
        .m1_req_i(m1_req_i), .m1_ack_o(rr_m1_ack), .m1_we_i(m1_we_i),
        .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi),
        .m1_resp_o(rr_m1_resp), .m1_rdata_bo(rr_m1_rdata),
        .s_req_o(rr_s_req), .s_ack_i(s_ack_i), .s_we_o(rr_s_we),
        .s_addr_bo(rr_s_addr), .s_be_bo(rr_s_be), .s_wdata_bo(rr_s_wdata),
        .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .resp_err_o(rr_resp_err)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic iss_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input logic id, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        if (id) begin
            m1_req_i = req; m1_we_i = we; m1_addr_bi = addr; m1_be_bi = be; m1_wdata_bi = wdata;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_addr_bi = addr; m0_be_bi = be; m0_wdata_bi = wdata;
        end
    endtask

    // Drive a response; the expected issuer comes from the bench's own read order.
    task automatic resp_drive(input logic [31:0] data);
        exp_t e;
        if (iss_q.size() > 0) begin
            e.id   = iss_q.pop_front();
            e.data = data;
            exp_q.push_back(e);
        end
        s_resp_i   = 1'b1;
        s_rdata_bi = data;
    endtask

    task automatic send_resp(input logic [31:0] data);
        resp_drive(data);
        @(posedge clk_i); #1;
        s_resp_i   = 1'b0;
        s_rdata_bi = '0;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic do_xfer(input logic id, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input bit resp_too, input logic [31:0] rdata, output int lat);
        bit ok;
        ok  = 0;
        lat = 0;
        set_m(id, 1'b1, we, addr, be, wdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            lat++;
            if (s_req_o) begin
                ok = 1;
                break;
            end
        end
        check("sreq_wait", ok, 1);
        if (ok) begin
            check("s_we", s_we_o, we);
            check("s_addr", s_addr_bo, addr);
            check("s_be", s_be_bo, be);
            check("s_wdata", s_wdata_bo, wdata);
            #1;
            s_ack_i = 1'b1;
            if (resp_too) resp_drive(rdata);
            #1;
            check("ack_granted", id ? m1_ack_o : m0_ack_o, 1);
            check("ack_other", id ? m0_ack_o : m1_ack_o, 0);
        end
        @(posedge clk_i); #1;
        s_ack_i  = 1'b0;
        s_resp_i = 1'b0;
        set_m(id, 1'b0, 1'b0, '0, '0, '0);
        if (ok && !we) iss_q.push_back(id);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        #2;
        if (m0_resp_o || m1_resp_o) begin
            check("resp_onehot", m0_resp_o && m1_resp_o, 0);
            if (exp_q.size() == 0) begin
                check("resp_spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", m1_resp_o, e.id);
                check("resp_data", e.id ? m1_rdata_bo : m0_rdata_bo, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;

        #2;
        check("rst_s_req", s_req_o, 0);
        check("rst_acks", {m0_ack_o, m1_ack_o}, 0);
        check("rst_resps", {m0_resp_o, m1_resp_o}, 0);
        check("rst_s_addr", s_addr_bo, 0);
        check("rst_s_wdata", s_wdata_bo, 0);
        check("rst_rdata", {m0_rdata_bo, m1_rdata_bo}, 0);
        check("rst_err", resp_err_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Single read from m0, response three cycles after the ack
        do_xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 0, 0, lat);
        check("lat_single", lat, 2);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        send_resp(32'hDEADBEEF);
        check("single_m1_quiet", m1_resp_o, 0);

        // Interleaved reads m0, m1, m0
        do_xfer(1'b0, 1'b0, 32'h20, 4'h1, 0, 0, 0, lat);
        do_xfer(1'b1, 1'b0, 32'h24, 4'h2, 0, 0, 0, lat);
        do_xfer(1'b0, 1'b0, 32'h28, 4'h4, 0, 0, 0, lat);
        send_resp(32'h1);
        send_resp(32'h2);
        send_resp(32'h3);

        // Push and pop in the same cycle with two entries outstanding
        do_xfer(1'b0, 1'b0, 32'h70, 4'hF, 0, 0, 0, lat);
        do_xfer(1'b1, 1'b0, 32'h74, 4'hF, 0, 0, 0, lat);
        do_xfer(1'b0, 1'b0, 32'h78, 4'hF, 0, 1, 32'h11, lat);
        send_resp(32'h22);
        send_resp(32'h33);

        // FIFO full: the fifth read stalls until a response pops an entry
        for (int k = 0; k < 4; k++)
            do_xfer(1'b1, 1'b0, 32'h40 + 32'(4 * k), 4'hF, 0, 0, 0, lat);
        set_m(1'b1, 1'b1, 1'b0, 32'h54, 4'hF, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("full_stall", s_req_o, 0);
        end
        @(posedge clk_i); #1;
        resp_drive(32'hA0);
        @(negedge clk_i);
        check("stall_pop_cycle", s_req_o, 0);
        @(posedge clk_i); #1;
        s_resp_i = 1'b0;
        do_xfer(1'b1, 1'b0, 32'h54, 4'hF, 0, 0, 0, lat);
        check("lat_unstall", lat, 1);
        send_resp(32'hA1);
        send_resp(32'hA2);
        send_resp(32'hA3);
        send_resp(32'hA4);

        // Contention with continuous writes from both masters
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        set_m(1'b0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hAAAA0000);
        set_m(1'b1, 1'b1, 1'b1, 32'h200, 4'hF, 32'hBBBB0000);
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                if (s_req_o) begin
                    ok = 1;
                    break;
                end
            end
            check("cont_wait", ok, 1);
            check("fixed_grant", s_addr_bo, 32'h100);
            check("rr_req", rr_s_req, 1);
            check("rr_grant", rr_s_addr, (k % 2 == 1) ? 32'h200 : 32'h100);
            #1;
            s_ack_i = 1'b1;
            #1;
            check("fixed_m1_ack", m1_ack_o, 0);
            @(posedge clk_i); #1;
            s_ack_i = 1'b0;
        end
        set_m(1'b0, 1'b0, 1'b0, 0, 0, 0);
        set_m(1'b1, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk_i); #1;

        // Response with nothing outstanding
        check("err_before", resp_err_o, 0);
        send_resp(32'h99);
        check("err_set", resp_err_o, 1);

        // Reset while GRANTED with one read outstanding
        do_xfer(1'b0, 1'b0, 32'h80, 4'hF, 0, 0, 0, lat);
        set_m(1'b0, 1'b1, 1'b0, 32'h84, 4'hF, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("pre_rst_req", s_req_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_sreq", s_req_o, 0);
        check("rst_mid_err", resp_err_o, 0);
        check("rst_mid_ack", m0_ack_o, 0);
        iss_q.delete();
        set_m(1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        send_resp(32'h55);
        check("err_after_rst", resp_err_o, 1);

        @(posedge clk_i); #1;
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udm_bus_arb.md
Name: udm_bus_arb

Overview:
- Two-master to one-slave arbiter on the udm bus protocol (req/ack/we/addr/be/wdata, resp/rdata).
- Master 0 is the udm debug controller; master 1 is the CPU data port.
- The block shares a single memory/peripheral slave between the two masters.
- It routes in-order read responses back to the issuing master through an ID FIFO.

Parameters:
- M0_PRIORITY, "YES": "YES" means fixed priority to master 0; "NO" means round-robin.
- RESP_FIFO_DEPTH, 4: maximum outstanding reads; must be a power of 2, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- m0_req_i  in  1  master 0 request (udm)
- m0_ack_o  out  1  master 0 request accepted
- m0_we_i  in  1  master 0 write enable
- m0_addr_bi  in  32  master 0 address
- m0_be_bi  in  4  master 0 byte enables
- m0_wdata_bi  in  32  master 0 write data
- m0_resp_o  out  1  master 0 read data valid
- m0_rdata_bo  out  32  master 0 read data
- m1_req_i, m1_ack_o, m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi, m1_resp_o, m1_rdata_bo: same as the m0_* ports, for master 1 (CPU)
- s_req_o  out  1  slave request
- s_ack_i  in  1  slave accepted request
- s_we_o  out  1  slave write enable
- s_addr_bo  out  32  slave address
- s_be_bo  out  4  slave byte enables
- s_wdata_bo  out  32  slave write data
- s_resp_i  in  1  slave read data valid
- s_rdata_bi  in  32  slave read data
- resp_err_o  out  1  sticky flag: s_resp_i arrived with no outstanding read

Behaviour:
- Reset values (asynchronous): all *_ack_o, *_resp_o and s_req_o are 0; all data/address outputs are 0; resp_err_o is 0; FSM is in IDLE; FIFO is empty; round-robin pointer favours master 0.
- Master rule: a master holds req/we/addr/be/wdata stable from req assertion until the cycle its ack is seen. The arbiter never aborts a granted request.
- FSM IDLE:
  - If any req is high, register grant_id and go to GRANTED.
  - Fixed mode: master 0 wins when both request.
  - Round-robin mode: on a tie, the master not served last wins.
  - Minimum latency from req to s_req_o is 1 cycle.
- FSM GRANTED:
  - s_req_o = granted master's req, gated by stall. s_we/addr/be/wdata are muxed from grant_id.
  - Stall: the granted request is a read (we=0) and the FIFO is full. While stalled, s_req_o is 0.
  - mX_ack_o = s_ack_i, for the granted master only. The ungranted ack is always 0.
  - When s_ack_i is high and s_req_o is high: if we=0, push grant_id into the FIFO. Return to IDLE. Update the round-robin pointer.
  - Back-to-back transactions from one master therefore take at least 2 cycles each.
- Response routing (combinational):
  - When s_resp_i=1 and the FIFO is non-empty, drive m[head]_resp_o=1 and m[head]_rdata_bo=s_rdata_bi, then pop.
  - The non-head master sees resp=0. Both rdata outputs may carry s_rdata_bi; masters qualify it with resp.
- Empty-FIFO response: when s_resp_i=1 and the FIFO is empty, no master resp is asserted and resp_err_o is set. It stays set until rst_i.
- Simultaneous push and pop: both take effect in the same cycle and the count is unchanged. A pop in the same cycle as a full-stall releases the stall on the next cycle.
- FIFO pointers: log2(RESP_FIFO_DEPTH) bits, wrap modulo depth. Count is one bit wider so full and empty are distinguishable.
- Writes produce no response and do not occupy the FIFO.
- Req dropped while granted: this violates the master rule. s_req_o follows it to 0, and the FSM stays GRANTED until ack.
- Reset mid-transaction: all state clears immediately. Outstanding responses are forgotten, so a later s_resp_i sets resp_err_o.

Test Plan:
- Single read, m0 addr 0x10: s_req_o rises 1 cycle after m0_req; ack at cycle N; s_resp_i with rdata 0xDEADBEEF at N+3 -> m0_resp_o=1 and m0_rdata_bo=0xDEADBEEF for one cycle; m1_resp_o=0.
- Contention with M0_PRIORITY="YES", both masters request writes continuously -> m0 always granted. With "NO" -> grants alternate m0,m1,m0,m1 over 4 transactions.
- FIFO full (depth 4): m1 issues 5 reads with s_resp_i held low -> 4 acks; s_req_o stays 0 for the 5th. One s_resp_i -> m1_resp_o=1 and the 5th read is issued the next cycle.
- Interleaved reads m0,m1,m0, responses 0x1,0x2,0x3 in order -> m0 receives 0x1 and 0x3; m1 receives 0x2.
- Pop and push in the same cycle with the FIFO at 2 entries -> count stays 2 and ordering is preserved.
- s_resp_i with an empty FIFO -> no master resp and resp_err_o=1. Assert rst_i mid-GRANTED -> s_req_o=0 immediately and resp_err_o=0.
